// File: rtl/div_unit_pkg.sv
// Shared encodings for the iterative RV32M divider: operation codes from the
// decoder and the divider FSM state constants.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage request/response bundle between the issue logic (master) and
// the divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       div_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, div_ctrl, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, div_ctrl, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left by one and subtract
// the divisor from the partial remainder when it fits.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // Shifted remainder needs WIDTH+1 bits because the divisor may use all WIDTH.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_fits  = (w_shift >= {1'b0, i_divisor});
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign o_rem   = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo   = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// with single-cycle handling of divide-by-zero and signed overflow.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  div_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_result;

  logic             w_signed;
  logic             w_is_rem;
  logic             w_b_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_special_res;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;
  logic [WIDTH-1:0] w_final;

  assign w_signed = (bus.div_ctrl == DIV_OP) || (bus.div_ctrl == REM_OP);
  assign w_is_rem = !((bus.div_ctrl == DIV_OP) || (bus.div_ctrl == DIVU_OP));
  assign w_b_zero = (bus.b == '0);
  assign w_ovf    = w_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
  // Negating the most-negative value yields 2^(WIDTH-1), still correct as unsigned.
  assign w_a_mag  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = w_is_rem ? bus.a : '1;
    else          w_special_res = w_is_rem ? '0 : bus.a;
  end

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_next_rem),
    .o_quo     (w_next_quo)
  );

  assign w_final = r_is_rem ? (r_neg_r ? -w_next_rem : w_next_rem)
                            : (r_neg_q ? -w_next_quo : w_next_quo);

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_divisor <= w_b_mag;
            r_is_rem  <= w_is_rem;
            r_neg_q   <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r   <= w_signed && bus.a[WIDTH-1];
            if (w_b_zero || w_ovf) begin
              r_result <= w_special_res;
              r_dbz    <= w_b_zero;
              r_done   <= 1'b1;
              r_state  <= S_FIN;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_cnt   <= CNT_W'(WIDTH-1);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_next_rem;
          r_quo <= w_next_quo;
          if (r_cnt == '0) begin
            r_result <= w_final;
            r_dbz    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.div_by_zero = r_dbz;

endmodule
